adder_tree_acc: RTL and testbench



---
 rtl/adder_tree_acc.sv | 129 ++++++++++++
 tb/tb_adder_tree_acc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined N-operand adder tree with optional running accumulator.
// Define ADDER_TREE_ACC_SAT_EN to saturate on overflow instead of wrapping.
module adder_tree_acc #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int SW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  ops,
   input  logic            cin,
   input  logic            mode,
   input  logic            acc_clr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SW-1:0]   sum,
   output logic            sum_zero,
   output logic            ovf,
   output logic            ovf_sticky
);
   localparam int L  = $clog2(N);
   localparam int P  = 1 << L;
   localparam int FW = W + L + 1;
   localparam int RW = ((SW > FW) ? SW : FW) + 1;

   logic            adv;
   logic [P*FW-1:0] lane0;
   logic [FW-1:0]   f_t;
   logic            f_v, f_c, f_m, f_k;

   logic            out_valid_q;
   logic [SW-1:0]   sum_q, sum_d;
   logic            zero_q;
   logic            ovf_q, ovf_d;
   logic            sticky_q, sticky_d;
   logic [SW-1:0]   acc_q;
   logic [SW-1:0]   base;
   logic [RW-1:0]   r;

   function automatic logic [P*FW-1:0] pair_add(input logic [P*FW-1:0] x);
      logic [P*FW-1:0] y;
      y = '0;
      for (int k = 0; k < P / 2; k++)
         y[k*FW +: FW] = x[2*k*FW +: FW] + x[(2*k+1)*FW +: FW];
      return y;
   endfunction

   // A stall freezes every stage, bubbles included.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   always_comb begin
      lane0 = '0;
      for (int k = 0; k < N; k++)
         lane0[k*FW +: FW] = FW'(ops[k*W +: W]);
   end

   if (L == 0) begin : g_flat
      assign f_t = lane0[FW-1:0];
      assign f_v = in_valid;
      assign f_c = cin;
      assign f_m = mode;
      assign f_k = acc_clr;
   end else begin : g_tree
      logic [P*FW-1:0] t_q [L];
      logic [3:0]      s_q [L];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int l = 0; l < L; l++) begin
               t_q[l] <= '0;
               s_q[l] <= '0;
            end
         end else if (adv) begin
            t_q[0] <= pair_add(lane0);
            s_q[0] <= {in_valid, cin, mode, acc_clr};
            for (int l = 1; l < L; l++) begin
               t_q[l] <= pair_add(t_q[l-1]);
               s_q[l] <= s_q[l-1];
            end
         end
      end

      assign f_t = t_q[L-1][FW-1:0];
      assign {f_v, f_c, f_m, f_k} = s_q[L-1];
   end

   // Final stage reads acc_q directly, so consecutive beats chain with no gap.
   always_comb begin
      base  = (f_m && !f_k) ? acc_q : '0;
      r     = RW'(base) + RW'(f_t) + RW'(f_c);
      ovf_d = |r[RW-1:SW];
`ifdef ADDER_TREE_ACC_SAT_EN
      sum_d = ovf_d ? '1 : r[SW-1:0];
`else
      sum_d = r[SW-1:0];
`endif
      sticky_d = (f_m && f_k) ? ovf_d : (sticky_q | ovf_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         sticky_q    <= 1'b0;
         acc_q       <= '0;
      end else if (adv) begin
         out_valid_q <= f_v;
         if (f_v) begin
            sum_q    <= sum_d;
            zero_q   <= (sum_d == '0);
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            if (f_m)
               acc_q <= sum_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign sum        = sum_q;
   assign sum_zero   = zero_q;
   assign ovf        = ovf_q;
   assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: SW=16 and SW=10 instances share one input stream.
// Expected saturation values follow ADDER_TREE_ACC_SAT_EN when it is defined.
module tb_adder_tree_acc;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, cin, mode, acc_clr;
   logic [31:0] ops;
   logic        in_ready, out_valid, sum_zero, ovf, ovf_sticky;
   logic [15:0] sum;
   logic        in_ready_b, out_valid_b, sum_zero_b, ovf_b, ovf_sticky_b;
   logic [9:0]  sum_b;

   always #5 clk = ~clk;

   adder_tree_acc #(.N(4), .W(8), .SW(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ops(ops), .cin(cin), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .sum_zero(sum_zero), .ovf(ovf), .ovf_sticky(ovf_sticky)
   );

   adder_tree_acc #(.N(4), .W(8), .SW(10)) u_dut10 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .ops(ops), .cin(cin), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
      .sum_zero(sum_zero_b), .ovf(ovf_b), .ovf_sticky(ovf_sticky_b)
   );

   typedef struct packed {
      logic [31:0] ops;
      logic        cin, mode, clr;
      logic [15:0] s;
      logic        z, v, st;
   } vec_t;

   vec_t tv [16];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic [31:0] o, input logic c, m, k,
                               input logic [15:0] s, input logic z, v, st);
      vec_t t;
      t = '{ops: o, cin: c, mode: m, clr: k, s: s, z: z, v: v, st: st};
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_tab(input int n, input bit b);
      vec_t e;
      for (int cyc = 0; cyc < n + 3; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 2)
            chk("lat_early", b ? out_valid_b : out_valid, 0);
         if (cyc >= 3) begin
            e = tv[cyc-3];
            chk("out_valid", b ? out_valid_b : out_valid, 1);
            chk("sum", b ? {22'b0, sum_b} : {16'b0, sum}, {16'b0, e.s});
            chk("sum_zero", b ? sum_zero_b : sum_zero, e.z);
            chk("ovf", b ? ovf_b : ovf, e.v);
            chk("ovf_sticky", b ? ovf_sticky_b : ovf_sticky, e.st);
         end
         if (cyc < n) begin
            chk("in_ready", b ? in_ready_b : in_ready, 1);
            in_valid = 1'b1;
            ops      = tv[cyc].ops;
            cin      = tv[cyc].cin;
            mode     = tv[cyc].mode;
            acc_clr  = tv[cyc].clr;
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   initial begin
      int          sent, hold_cnt, nout;
      bit          hold_started, p_in, p_out;
      logic [15:0] held, p_sum;
      logic [15:0] got [$];

      rst = 1'b1; in_valid = 0; out_ready = 1; ops = '0;
      cin = 0; mode = 0; acc_clr = 0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_zero", sum_zero, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sticky", ovf_sticky, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst_in_ready", in_ready, 1);

      tv[0] = mk(32'h04030201, 1, 0, 0, 16'd11,   0, 0, 0);
      tv[1] = mk(32'hFFFFFFFF, 1, 0, 0, 16'd1021, 0, 0, 0);
      tv[2] = mk(32'h00000000, 0, 0, 0, 16'd0,    1, 0, 0);
      tv[3] = mk(32'h04030201, 0, 1, 1, 16'd10,   0, 0, 0);
      tv[4] = mk(32'h05050505, 0, 1, 0, 16'd30,   0, 0, 0);
      tv[5] = mk(32'h05050A0A, 0, 1, 0, 16'd60,   0, 0, 0);
      tv[6] = mk(32'h00000007, 0, 0, 0, 16'd7,    0, 0, 0);
      tv[7] = mk(32'h00000000, 1, 1, 0, 16'd61,   0, 0, 0);
      run_tab(8, 0);

      repeat (3) @(posedge clk);
      tv[0] = mk(32'hFFFFFFFF, 1, 1, 1, 16'd1021, 0, 0, 0);
`ifdef ADDER_TREE_ACC_SAT_EN
      tv[1] = mk(32'hFFFFFFFF, 1, 1, 0, 16'd1023, 0, 1, 1);
`else
      tv[1] = mk(32'hFFFFFFFF, 1, 1, 0, 16'd1018, 0, 1, 1);
`endif
      tv[2] = mk(32'h00000001, 0, 0, 0, 16'd1,    0, 0, 1);
      tv[3] = mk(32'h01010101, 1, 1, 1, 16'd5,    0, 0, 0);
      run_tab(4, 1);

      repeat (3) @(posedge clk);
      sent = 0; hold_cnt = 0; hold_started = 0;
      p_in = 0; p_out = 0; p_sum = '0; held = '0;
      for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
         @(posedge clk); #1;
         if (p_out) got.push_back(p_sum);
         if (p_in) sent++;
         if (!hold_started && out_valid) begin
            hold_started = 1; hold_cnt = 5; held = sum;
         end
         out_ready = (hold_cnt == 0);
         in_valid  = (sent < 6);
         ops       = 32'(sent);
         cin       = 1'b1;
         mode      = 1'b0;
         acc_clr   = 1'b0;
         #1;
         if (hold_cnt > 0) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum_hold", sum, held);
            hold_cnt--;
         end
         p_in  = in_valid && in_ready;
         p_out = out_valid && out_ready;
         p_sum = sum;
      end
      in_valid = 0; out_ready = 1;
      chk("bp_count", got.size(), 6);
      for (int i = 0; i < got.size(); i++)
         chk("bp_order", got[i], 16'(i + 1));

      repeat (3) @(posedge clk);
      #1;
      in_valid = 1; ops = 32'h01010101; cin = 0; mode = 1; acc_clr = 0;
      @(posedge clk); #1;
      ops = 32'h02020202;
      @(posedge clk); #1;
      in_valid = 0; rst = 1'b1; #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_zero", sum_zero, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_sticky", ovf_sticky, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      nout = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) nout++;
      end
      chk("mid_rst_no_out", nout, 0);
      in_valid = 1; ops = 32'h00000201; cin = 0; mode = 1; acc_clr = 0;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("acc_clr_valid", out_valid, 1);
      chk("acc_after_rst", sum, 3);
      chk("acc_after_rst10", sum_b, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
